// File: rtl/serial_block_rx.sv
// UART 8N1 receiver feeding a BLOCK_BYTES-wide block assembler with a level ReadEn/ReadRy handshake.
// Optional partial-block idle timeout is compiled in with `define SERIAL_RX_TIMEOUT_EN.
module serial_block_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BLOCK_BYTES  = 16,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Rx,
  input  logic                       ReadEn,
  output logic [8*BLOCK_BYTES-1:0]   Block,
  output logic                       ReadRy,
  output logic                       FrameErr
);

  localparam int BW    = 8 * BLOCK_BYTES;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BC_W  = $clog2(BLOCK_BYTES + 1);

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BLOCK_BYTES - 1);

  // Elaboration-time guard: the half-bit start check needs a few clocks of room.
  if (CLKS_PER_BIT < 4 || BLOCK_BYTES < 2 || TIMEOUT_CLKS < 1) begin : g_bad_params
    $error("serial_block_rx: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rxs;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             byte_valid;
  logic [BC_W-1:0]  count;
  logic             timeout_hit;

  // Two-flop synchroniser; idle-high reset so a reset never looks like a start bit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      // NOTE: non-blocking everywhere in clocked logic so every flop sees pre-edge values.
      rx_meta <= Rx;
      rxs     <= rx_meta;
    end
  end

  // Bit-level receiver: byte_valid and FrameErr are single-cycle registered pulses.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      FrameErr   <= 1'b0;
    end else begin
      // NOTE: pulses default low each cycle; only the stop-bit branch raises them.
      byte_valid <= 1'b0;
      FrameErr   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state    <= ST_START;
            baud_cnt <= '0;
          end
        end
        ST_START: begin
          if (baud_cnt == HALF_BIT) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_cnt == LAST_CLK) begin
            baud_cnt <= '0;
            shreg    <= {rxs, shreg[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_cnt == LAST_CLK) begin
            baud_cnt   <= '0;
            byte_valid <= rxs;
            FrameErr   <= ~rxs;
            state      <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERIAL_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CLKS);

  logic [IDLE_W-1:0] idle_cnt;

  // Only a genuinely quiet line with a partial block counts towards the timeout.
  assign timeout_hit = (idle_cnt == IDLE_LIMIT) && (state == ST_IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      idle_cnt <= '0;
    end else if (count == '0 || ReadRy || state != ST_IDLE || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Block assembler and handshake; Block only moves while a block is being gathered.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count  <= '0;
      ReadRy <= 1'b0;
      Block  <= '0;
    end else if (ReadRy) begin
      if (!ReadEn) ReadRy <= 1'b0;
    end else if (!ReadEn || timeout_hit) begin
      count <= '0;
    end else if (byte_valid) begin
      Block <= {Block[BW-9:0], shreg};
      if (count == LAST_BYTE) begin
        ReadRy <= 1'b1;
        count  <= '0;
      end else begin
        count <= count + BC_W'(1);
      end
    end
  end

endmodule

// File: doc/serial_block_rx.md
Name: serial_block_rx

Overview:
- UART receive front end plus 128-bit block assembler; sits directly upstream of the AES encryptor.
- Samples the Rx pin and deserialises 8N1 bytes.
- Packs 16 consecutive bytes into one plaintext block.
- Hands the block to the controller with a level ReadEn/ReadRy handshake; Block then drives the encryptor PT input.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be >= 4.
- BLOCK_BYTES, 16, bytes per assembled block; Block width is 8*BLOCK_BYTES.
- TIMEOUT_CLKS, 50000, idle clocks before a partial block is discarded (used only with the optional feature).

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous active-high reset.
- Rx  in  1  asynchronous UART serial input; idle high.
- ReadEn  in  1  controller request: arm capture of one block.
- Block  out  128  assembled block; first received byte in [127:120], last byte in [7:0].
- ReadRy  out  1  block complete and stable; level signal.
- FrameErr  out  1  one-cycle pulse on a bad stop bit.

Behaviour:
- One clock domain (Clk). Reset is synchronous and active-high on Rst.
- Reset values: Block=0, ReadRy=0, FrameErr=0, byte count=0, bit FSM=IDLE. Both synchroniser flops reset to 1.
- Rx passes through a 2-flop synchroniser; all logic uses the synchronised value rxs (2-cycle latency).
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: rxs==0 -> START, baud counter cleared.
  - START: at count CLKS_PER_BIT/2 (integer division), rxs==1 -> IDLE (glitch rejected, nothing recorded). Otherwise -> DATA with counter cleared.
  - DATA: sample rxs every CLKS_PER_BIT clocks. Shift in LSB first. After the 8th sample -> STOP.
  - STOP: one CLKS_PER_BIT later, sample rxs.
    - rxs==1: byte valid.
    - rxs==0: FrameErr=1 for exactly one cycle, byte discarded, byte count unchanged.
    - Either way -> IDLE.
- Block assembly:
  - A valid byte is accepted only when ReadEn==1 and ReadRy==0. Otherwise it is dropped silently.
  - On accept: Block <= {Block[119:0], byte}; count increments.
  - On the accept that makes count==BLOCK_BYTES: ReadRy<=1 in the same registered update, and count<=0.
- Handshake:
  - ReadRy stays high while ReadEn stays high; Block is frozen while ReadRy==1.
  - ReadEn falling while ReadRy==1: ReadRy clears on the next clock edge.
  - ReadEn falling mid-block (ReadRy==0): count resets to 0 and the partial block is discarded. The bit FSM continues uninterrupted.
  - A new block starts only after ReadRy has returned to 0 and ReadEn is high again.
- Rst asserted mid-byte or mid-block: all state returns to reset values on that edge; no partial data survives.
- Counters:
  - The baud counter wraps to 0 at each sample point.
  - Byte count width is clog2(BLOCK_BYTES+1); it never exceeds BLOCK_BYTES.
- Latency: ReadRy rises (2 + ~9.5*CLKS_PER_BIT) clocks after the falling edge of the last byte's start bit.

Optional Feature:
- Macro: SERIAL_RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs while count>0, ReadRy==0 and the bit FSM is in IDLE.
  - Any start bit clears the idle counter.
  - On reaching TIMEOUT_CLKS: count<=0, partial block discarded, no output pulse.
- Not defined: the idle counter is absent; a partial block waits indefinitely.

Test Plan:
- All tests use CLKS_PER_BIT=8.
- Reset then ReadEn=1; send bytes 0x00,0x11,...,0xFF (16 bytes) -> ReadRy=1, Block=128'h00112233445566778899AABBCCDDEEFF, FrameErr never 1.
- Hold ReadEn=1 after ReadRy and send 3 extra bytes -> Block unchanged. Drop ReadEn -> ReadRy=0 exactly 1 clock later.
- Send byte 0xA5 with stop bit=0 -> FrameErr high exactly 1 cycle, count unchanged. The next 16 good bytes form the block.
- Pulse Rx low for 3 clocks -> no byte recorded, FSM back in IDLE.
- Send 7 bytes, drop ReadEn, raise it, send 16 bytes 0x01..0x10 -> Block=128'h0102030405060708090A0B0C0D0E0F10.
- With SERIAL_RX_TIMEOUT_EN, TIMEOUT_CLKS=200: send 5 bytes, idle 250 clocks, send 16 bytes 0xF0..0xFF -> Block=128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF.
- Without the macro, the same sequence -> ReadRy after the 11th of the second group.
- Assert Rst during bit 4 of byte 9 -> all outputs 0 next cycle; a fresh 16 bytes complete normally.
